vacc_dump_ctrl: RTL

Controller that sequences dumps from the vector accumulator. It issues the accumulator's `trig`, watches the drain write stream (`we`/`addr`) to detect dump completion, and ping-pongs the output buffer between two halves of the readout BRAM. It also runs a ready/ack handshake with the host, with overrun and timeout reporting. It sits between the software register interface and the accumulator/readout-BRAM pair.

---
 rtl/vacc_dump_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vacc_dump_ctrl.sv
// Dump sequencer for the vector accumulator: issues trig, tracks the drain write
// stream, ping-pongs the readout BRAM halves and handshakes dumps with the host.
module vacc_dump_ctrl #(
  parameter int unsigned VECTOR_WIDTH   = 11,
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    arm,
  input  logic                    continuous,
  input  logic                    stop,
  input  logic                    host_ack,
  input  logic                    clr_err,
  input  logic                    vacc_we,
  input  logic [VECTOR_WIDTH-1:0] vacc_addr,
  output logic                    trig,
  output logic                    wr_buf,
  output logic                    rd_buf,
  output logic                    dump_ready,
  output logic [COUNT_WIDTH-1:0]  dump_count,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [VECTOR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRIGGERED,
    S_DRAINING,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_trig;
  logic                   r_busy;
  logic                   r_wr_buf;
  logic                   r_rd_buf;
  logic                   r_dump_ready;
  logic [COUNT_WIDTH-1:0] r_dump_count;
  logic                   r_overrun;
  logic                   r_timeout;
  logic                   r_stop_pend;
  logic [TW-1:0]          r_tmo_cnt;

  logic w_last_wr;
  logic w_stop_pend;

  assign w_last_wr   = vacc_we && (vacc_addr == ADDR_LAST);
  // A stop arriving in the DONE cycle itself still prevents the re-trigger.
  assign w_stop_pend = r_stop_pend | stop;

  // Later non-blocking writes in the case arms override the generic clears
  // above them: that gives set-over-clear for the sticky flags and dump_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_trig       <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_buf     <= 1'b0;
      r_rd_buf     <= 1'b0;
      r_dump_ready <= 1'b0;
      r_dump_count <= '0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_tmo_cnt    <= '0;
    end else if (ce) begin
      if (clr_err) begin
        r_overrun <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (host_ack)
        r_dump_ready <= 1'b0;
      if (stop && (r_state != S_IDLE))
        r_stop_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (arm || continuous) begin
            r_state   <= S_TRIGGERED;
            r_trig    <= 1'b1;
            r_busy    <= 1'b1;
            r_tmo_cnt <= '0;
          end
        end
        S_TRIGGERED: begin
          if (vacc_we) begin
            r_state <= S_DRAINING;
            r_trig  <= 1'b0;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_state     <= S_IDLE;
            r_trig      <= 1'b0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b1;
            r_stop_pend <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        S_DRAINING: begin
          if (w_last_wr) begin
            r_state      <= S_DONE;
            r_dump_count <= r_dump_count + COUNT_WIDTH'(1);
            r_rd_buf     <= r_wr_buf;
            r_wr_buf     <= ~r_wr_buf;
            r_dump_ready <= 1'b1;
            if (r_dump_ready && !host_ack)
              r_overrun <= 1'b1;
          end
        end
        S_DONE: begin
          if (continuous && !w_stop_pend) begin
            r_state   <= S_TRIGGERED;
            r_trig    <= 1'b1;
            r_tmo_cnt <= '0;
          end else begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_stop_pend <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_trig      <= 1'b0;
          r_busy      <= 1'b0;
          r_stop_pend <= 1'b0;
        end
      endcase
    end
  end

  assign trig       = r_trig;
  assign busy       = r_busy;
  assign wr_buf     = r_wr_buf;
  assign rd_buf     = r_rd_buf;
  assign dump_ready = r_dump_ready;
  assign dump_count = r_dump_count;
  assign overrun    = r_overrun;
  assign timeout    = r_timeout;

endmodule
